mem_arbiter: RTL and testbench

- Shares the single main-memory port between instruction-cache refills and data-cache refills/writebacks.
- Sits between the icache/dcache miss logic and the memory model.
- Serialises one transaction at a time with round-robin arbitration on ties.
- Pulses a one-cycle response back to the owning cache.

---
 rtl/brisc_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared types and sizes for the brisc cache/memory subsystem
package brisc_pkg;

    localparam int LINE_WIDTH = 128;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_arb_state_e;

    typedef enum logic {REQ_IC, REQ_DC} requester_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache/dcache line transactions onto one memory port
// with round-robin tie-breaking and a one-cycle response pulse to the owner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = brisc_pkg::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_rsp_valid,
    output logic [LINE_WIDTH-1:0] ic_rsp_rdata,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic                  dc_rsp_valid,
    output logic [LINE_WIDTH-1:0] dc_rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mem_rsp_rdata,
    output logic                  busy
);
    import brisc_pkg::*;

    mem_arb_state_e        state, state_nx;
    requester_e            owner, last_grant, pick;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [LINE_WIDTH-1:0] wdata_q, rdata_q;
    logic                  grant;

    // A lone requester wins; on a tie the one that did not win last time wins.
    assign pick  = (dc_req && (!ic_req || last_grant == REQ_IC)) ? REQ_DC : REQ_IC;
    assign grant = state == IDLE && (ic_req || dc_req);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? REQ : IDLE;
            REQ:     state_nx = mem_req_ready ? WAIT : REQ;
            WAIT:    state_nx = mem_rsp_valid ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= REQ_IC;
            last_grant <= REQ_IC;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= pick;
                addr_q  <= pick == REQ_DC ? dc_addr : ic_addr;
                we_q    <= pick == REQ_DC && dc_we;
                wdata_q <= pick == REQ_DC ? dc_wdata : '0;
            end
            if (state == WAIT && mem_rsp_valid)
                rdata_q <= mem_rsp_rdata;
            if (state == RESP)
                last_grant <= owner;
        end
    end

    assign mem_req_valid = state == REQ;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign ic_rsp_valid  = state == RESP && owner == REQ_IC;
    assign dc_rsp_valid  = state == RESP && owner == REQ_DC;
    assign ic_rsp_rdata  = rdata_q;
    assign dc_rsp_rdata  = rdata_q;
    assign busy          = state != IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench with a timestamp-based transaction model
// of the arbiter and a behavioural line memory.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ic_req, dc_req, dc_we, mem_req_ready, mem_rsp_valid;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata, mem_rsp_rdata;
    logic          ic_rsp_valid, dc_rsp_valid, mem_req_valid, mem_req_we, busy;
    logic [LW-1:0] ic_rsp_rdata, dc_rsp_rdata, mem_req_wdata;
    logic [AW-1:0] mem_req_addr;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_rdata(ic_rsp_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_rdata(dc_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [LW-1:0] store [logic [AW-1:0]];
    int seen [$];
    int ic_rsp_c = -100;

    // current transaction: owner, fields and the cycles of grant/accept/memory response
    bit            have, t_dc, t_we, last_dc;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_wdata, t_rdata;
    int            grant_c, accept_c, mrsp_c, free_c;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic logic [AW-1:0] raddr();
        return AW'($urandom_range(0, 31)) << 4;
    endfunction

    function automatic logic [LW-1:0] rline();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] memval(input logic [AW-1:0] a);
        return store.exists(a) ? store[a] : {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'd1};
    endfunction

    task automatic step(input int p_ic, input int p_dc, input int p_we, input int p_rdy,
                        input int lo, input int hi, input int fx = 0,
                        input logic [AW-1:0] ia = '0, input logic [AW-1:0] da = '0,
                        input logic [LW-1:0] dw = '0);
        bit ev_mv, ev_busy, rsp_now;
        @(negedge clk);
        cyc++;
        ev_mv   = have && cyc > grant_c && (accept_c < 0 || cyc <= accept_c);
        ev_busy = have && cyc > grant_c && (mrsp_c < 0 || cyc <= mrsp_c + 1);
        rsp_now = have && mrsp_c >= 0 && cyc == mrsp_c + 1;
        if (ic_rsp_valid) begin seen.push_back(0); ic_rsp_c = cyc; end
        if (dc_rsp_valid) seen.push_back(1);
        chk("mem_req_valid", LW'(mem_req_valid), LW'(ev_mv));
        chk("busy", LW'(busy), LW'(ev_busy));
        chk("ic_rsp_valid", LW'(ic_rsp_valid), LW'(rsp_now && !t_dc));
        chk("dc_rsp_valid", LW'(dc_rsp_valid), LW'(rsp_now && t_dc));
        if (ev_mv) begin
            chk("mem_req_addr", LW'(mem_req_addr), LW'(t_addr));
            chk("mem_req_we", LW'(mem_req_we), LW'(t_we));
            chk("mem_req_wdata", mem_req_wdata, t_wdata);
        end
        if (rsp_now) begin
            chk(t_dc ? "dc_rsp_rdata" : "ic_rsp_rdata", t_dc ? dc_rsp_rdata : ic_rsp_rdata, t_rdata);
            have    = 1'b0;
            last_dc = t_dc;
            free_c  = cyc + 1;
        end
        ic_req        = pct(p_ic);
        dc_req        = pct(p_dc);
        dc_we         = pct(p_we);
        ic_addr       = fx != 0 ? ia : raddr();
        dc_addr       = fx != 0 ? da : raddr();
        dc_wdata      = fx != 0 ? dw : rline();
        mem_req_ready = pct(p_rdy);
        mem_rsp_valid = have && cyc == mrsp_c;
        mem_rsp_rdata = rline();
        if (have && cyc == mrsp_c) begin
            if (!t_we) mem_rsp_rdata = memval(t_addr);
            t_rdata = mem_rsp_rdata;
        end
        if (have && cyc > grant_c && accept_c < 0 && mem_req_ready) begin
            accept_c = cyc;
            mrsp_c   = cyc + int'($urandom_range(lo, hi));
            if (t_we) store[t_addr] = t_wdata;
        end
        if (!have && cyc >= free_c && (ic_req || dc_req)) begin
            have     = 1'b1;
            t_dc     = dc_req && (!ic_req || !last_dc);
            t_addr   = t_dc ? dc_addr : ic_addr;
            t_we     = t_dc && dc_we;
            t_wdata  = t_dc ? dc_wdata : '0;
            grant_c  = cyc;
            accept_c = -1;
            mrsp_c   = -1;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, released on a later falling edge,
    // followed by a stray memory response while idle.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", LW'(busy), '0);
        chk("rst_mem_req_valid", LW'(mem_req_valid), '0);
        chk("rst_mem_req_we", LW'(mem_req_we), '0);
        chk("rst_mem_req_addr", LW'(mem_req_addr), '0);
        chk("rst_mem_req_wdata", mem_req_wdata, '0);
        chk("rst_ic_rsp_valid", LW'(ic_rsp_valid), '0);
        chk("rst_dc_rsp_valid", LW'(dc_rsp_valid), '0);
        chk("rst_ic_rsp_rdata", ic_rsp_rdata, '0);
        chk("rst_dc_rsp_rdata", dc_rsp_rdata, '0);
        {ic_req, dc_req, dc_we, mem_req_ready, mem_rsp_valid} = '0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rsp_rdata = '0;
        have = 1'b0; last_dc = 1'b0; accept_c = -1; mrsp_c = -1; grant_c = 0;
        seen.delete();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rline();
        free_c = cyc;
    endtask

    initial begin
        int n0;
        do_reset();
        // single icache read, ready=1, memory latency 1
        store[32'h1000] = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        step(100, 0, 0, 100, 1, 1, 1, 32'h1000);
        n0 = cyc;
        repeat (5) step(0, 0, 0, 100, 1, 1);
        chk("t1_rsp_cycle", LW'(ic_rsp_c - n0), LW'(3));
        chk("t1_ic_pulses", LW'(seen.size()), LW'(1));
        // tie straight after reset goes to DC, then strict alternation
        do_reset();
        repeat (26) step(100, 100, 0, 100, 1, 1, 1, 32'h1000, 32'h2000);
        chk("t3_count", LW'(seen.size() >= 6), LW'(1));
        for (int i = 0; i < 6; i++)
            chk("t3_order", LW'(i < seen.size() ? seen[i] : 2), LW'(i % 2 == 0));
        // writeback held off by ready low for 5 cycles
        repeat (8) step(0, 0, 0, 100, 1, 1);
        n0 = seen.size();
        step(0, 100, 100, 0, 1, 1, 1, '0, 32'h3040, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        repeat (5) step(0, 0, 50, 0, 1, 1);
        step(0, 0, 0, 100, 2, 2);
        repeat (5) step(0, 0, 0, 100, 1, 1);
        chk("t4_dc_pulses", LW'(seen.size() - n0), LW'(1));
        // request dropped and address changed while waiting on memory
        n0 = seen.size();
        step(0, 100, 0, 100, 4, 4, 1, '0, 32'h3040);
        repeat (7) step(0, 0, 50, 100, 4, 4);
        chk("t5_dc_pulses", LW'(seen.size() - n0), LW'(1));
        // reset while waiting on memory; the next tie must again go to DC
        step(0, 100, 0, 100, 6, 6, 1, '0, 32'h6000);
        repeat (3) step(0, 0, 0, 100, 6, 6);
        do_reset();
        repeat (5) step(100, 100, 0, 100, 1, 1);
        chk("t6_first_after_reset", LW'(seen.size() > 0 ? seen[0] : 2), LW'(1));
        // randomized traffic
        repeat (1500) step(70, 70, 40, 60, 1, 4);
        repeat (500) step(100, 100, 50, 80, 1, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
